// File: rtl/count_down_timer_pkg.sv
// Shared types and constants for the count-down timer slice.
package count_down_timer_pkg;

   localparam int DEFAULT_WIDTH = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // Width of a phase counter that must hold values 0 .. div-1 (at least 1 bit).
   function automatic int unsigned div_cnt_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/count_down_timer_if.sv
// Control/status bundle of the count-down timer: the master drives load,
// load_val, start and stop; the slave (the timer) returns count_out, busy,
// done and zero.
interface count_down_timer_if
   import count_down_timer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             start;
   logic             stop;
   logic [WIDTH-1:0] count_out;
   logic             busy;
   logic             done;
   logic             zero;

   modport master (
      output load, load_val, start, stop,
      input  count_out, busy, done, zero
   );

   modport slave (
      input  load, load_val, start, stop,
      output count_out, busy, done, zero
   );

endinterface

// File: rtl/count_down_timer_tick_div.sv
// Prescaler for the count-down timer: emits a one-cycle tick every DIV clocks
// while clear is low; clear restarts the phase so the first tick after clear
// falls DIV edges after the last cleared edge.
module tick_div
   import count_down_timer_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned   CW   = div_cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] phase;

   assign tick = !clear && (phase == LAST);

   // Phase counter: held at zero while cleared, wraps after the last phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= '0;
      end else if (clear || phase == LAST) begin
         phase <= '0;
      end else begin
         phase <= phase + CW'(1);
      end
   end

endmodule

// File: rtl/count_down_timer.sv
// Count-down timer with IDLE/RUN/PAUSE control, DIV-cycle prescaler and a
// one-cycle done pulse on terminal count.
// Optional feature macro: DOWNCOUNT_AUTORELOAD_EN -- when defined, the terminal
// count reloads the last loaded value and keeps running instead of stopping.
module count_down_timer
   import count_down_timer_pkg::*;
#(
   parameter int          WIDTH = DEFAULT_WIDTH,
   parameter int unsigned DIV   = 1
) (
   input  logic              clk,
   input  logic              reset,
   count_down_timer_if.slave bus
);

   state_t           state;
   logic [WIDTH-1:0] count;
   logic             busy_q;
   logic             done_q;
   logic             tick;
   logic             clear;
`ifdef DOWNCOUNT_AUTORELOAD_EN
   logic [WIDTH-1:0] reload;
`endif

   // The prescaler only runs in RUN; holding it clear elsewhere restarts the
   // phase on every entry to RUN.
   assign clear = (state != RUN);

   tick_div #(
      .DIV (DIV)
   ) u_tick_div (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .tick  (tick)
   );

   assign bus.count_out = count;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.zero      = (count == '0);

   // Control FSM with count, busy and done registered alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         count  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef DOWNCOUNT_AUTORELOAD_EN
         reload <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (bus.load) begin
            count  <= bus.load_val;
            state  <= IDLE;
            busy_q <= 1'b0;
`ifdef DOWNCOUNT_AUTORELOAD_EN
            reload <= bus.load_val;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start && count != '0) begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                  end
               end
               RUN: begin
                  if (bus.stop) begin
                     state  <= PAUSE;
                     busy_q <= 1'b0;
                  end else if (count == '0) begin
                     // Never decrement through zero; fall back to IDLE.
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else if (tick) begin
                     if (count == WIDTH'(1)) begin
                        done_q <= 1'b1;
`ifdef DOWNCOUNT_AUTORELOAD_EN
                        if (reload != '0) begin
                           count <= reload;
                        end else begin
                           count  <= '0;
                           state  <= IDLE;
                           busy_q <= 1'b0;
                        end
`else
                        count  <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
`endif
                     end else begin
                        count <= count - WIDTH'(1);
                     end
                  end
               end
               PAUSE: begin
                  if (bus.start) begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
